spike_inject_arbiter: RTL
=========================

Name: spike_inject_arbiter

Overview:
- Round-robin arbiter and time-step scheduler on rt_clk that shares one router local injection port among NUM_REQ spike sources.
- Sources include controller stimulus, replay buffer and debug port.
- Injection is allowed only inside a fixed window of WINDOW cycles after each step_start, and at most MAX_INJ packets per step.
- Sits between the mesh controller's spike sources and the boundary router's local_in/write_en_local/local_neuron_full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- PKT_W, 32, spike packet width
- WINDOW, 64, rt_clk cycles per step during which injection is permitted
- MAX_INJ, 16, packet budget per step
- CNT_W, 8, width of inject_count and the window counter; must hold both WINDOW and MAX_INJ

Ports:
- rt_clk  in  1  router clock; the only clock
- rt_reset  in  1  asynchronous, active-high reset
- step_start  in  1  one-cycle pulse that opens a step window
- req  in  NUM_REQ  per-source request; held high with a stable packet until ack
- packet_in  in  NUM_REQ*PKT_W  source i occupies bits [i*PKT_W +: PKT_W]
- ack  out  NUM_REQ  one-hot, combinational, high in the cycle source i is granted
- packet_out  out  PKT_W  registered packet to router local_in
- write_req  out  1  registered write strobe to router write_en_local
- router_full  in  1  router local_neuron_full
- step_done  out  1  one-cycle pulse when a window closes
- inject_count  out  CNT_W  packets injected in the current/last step
- overrun  out  1  sticky; set when step_start arrives outside IDLE

Behaviour:
- Reset (asynchronous, active-high): all outputs go to 0 immediately. State = IDLE, rr pointer = NUM_REQ-1 so req[0] has first priority. Any in-flight packet is discarded; write_req drops in the same instant.
- FSM states: IDLE, ACTIVE, DONE.
- IDLE:
  - ack=0.
  - On step_start: go to ACTIVE, window counter=0, inject_count=0.
- ACTIVE, grant condition for cycle t: any req, router_full=0, and inject_count<MAX_INJ.
  - The winner is the first set req[i] searched from (ptr+1) mod NUM_REQ upward with wrap.
  - ack[winner]=1 combinationally in cycle t.
  - At the edge ending cycle t: packet_out<=packet_in[winner], write_req<=1, ptr<=winner, inject_count<=inject_count+1.
  - Grant-to-write latency is 1 cycle. Back-to-back grants are allowed, giving one packet per cycle.
- Not granting in ACTIVE (router_full=1, budget exhausted, or no req): ack=0, write_req<=0, ptr unchanged, and packet_out holds its last value.
- Window counter increments every ACTIVE cycle. In the cycle it equals WINDOW-1, grants are still allowed, then the FSM moves to DONE.
- DONE (1 cycle):
  - ack=0, write_req<=0.
  - step_done=1.
  - Go to IDLE.
  - inject_count holds its value until the next step_start.
- Pending requests are never dropped: an ungranted source keeps req high into the next step.
- step_start in ACTIVE or DONE: ignored for sequencing; overrun<=1 (cleared only by rt_reset).
- step_start in the same cycle as the DONE→IDLE transition: counts as overrun; it is not queued.
- Router contract: router_full must assert while the FIFO has ≤1 free entry, so the registered write after a grant is always accepted.
- Requester contract: a source may drop req or change packet_in only in the cycle after ack. A req that falls without an ack is a legal withdrawal.
- inject_count never exceeds MAX_INJ. There is no wrap.

Test Plan:
- Single source: reset, step_start, req[2]=1 with packet 0xA5A5_0001 held → ack[2] in the next cycle, write_req=1 with packet_out=0xA5A5_0001 one cycle later, inject_count=1.
- Round-robin: all four req held continuously, packets 0x10..0x13 → grant order 0,1,2,3,0,1… with one write per cycle; after 8 grants, inject_count=8.
- Backpressure: router_full=1 for 5 cycles mid-stream → ack=0 and write_req=0 throughout, ptr unchanged, the same source is granted first when full drops, and no packet is lost or duplicated.
- Budget and window (MAX_INJ=16, WINDOW=64) with requests always pending:
  - Exactly 16 writes occur, then no ack until step_done pulses at cycle 64 after step_start, with inject_count=16.
  - The next step_start clears inject_count.
- Overrun: step_start pulsed at cycle 10 of ACTIVE → no restart, step_done still at cycle 64, overrun=1 and remains set until rt_reset.
- Reset mid-transfer: assert rt_reset while write_req=1 → write_req, ack, step_done and inject_count go to 0 immediately. After release, the first grant goes to req[0] when all sources request.

Source files
------------

// File: rtl/spike_inject_arbiter.sv
// spike_inject_arbiter
// Round-robin sharing of one router local injection port among NUM_REQ spike
// sources. Injection is confined to a WINDOW-cycle window opened by each
// step_start and limited to MAX_INJ packets per step.

module spike_inject_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PKT_W   = 32,
   parameter int WINDOW  = 64,
   parameter int MAX_INJ = 16,
   parameter int CNT_W   = 8
) (
   input  logic                     rt_clk,
   input  logic                     rt_reset,
   input  logic                     step_start,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*PKT_W-1:0] packet_in,
   output logic [NUM_REQ-1:0]       ack,
   output logic [PKT_W-1:0]         packet_out,
   output logic                     write_req,
   input  logic                     router_full,
   output logic                     step_done,
   output logic [CNT_W-1:0]         inject_count,
   output logic                     overrun
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0] INJ_MAX  = CNT_W'(MAX_INJ);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t               state_q;
   logic [PTR_W-1:0]     ptr_q;
   logic [CNT_W-1:0]     win_cnt_q;
   logic [CNT_W-1:0]     inject_count_q;
   logic [PKT_W-1:0]     packet_out_q;
   logic                 write_req_q;
   logic                 step_done_q;
   logic                 overrun_q;

   logic                 grant_s;
   logic [PTR_W-1:0]     winner_s;
   logic [NUM_REQ-1:0]   ack_s;
   logic [PKT_W-1:0]     win_pkt_s;
   int                   cand_s;

   // Winner search: first set request after the last winner, wrapping around.
   always_comb begin
      grant_s  = 1'b0;
      winner_s = ptr_q;
      cand_s   = 0;
      if ((state_q == ST_ACTIVE) && !router_full && (inject_count_q < INJ_MAX)) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = (int'(ptr_q) + k) % NUM_REQ;
            if (!grant_s && req[cand_s]) begin
               grant_s  = 1'b1;
               winner_s = PTR_W'(cand_s);
            end else begin
               grant_s  = grant_s;
            end
         end
      end else begin
         grant_s  = 1'b0;
         winner_s = ptr_q;
      end
   end

   // One-hot acknowledge and packet select for the granted source.
   always_comb begin
      ack_s     = '0;
      win_pkt_s = packet_in[int'(winner_s)*PKT_W +: PKT_W];
      if (grant_s) begin
         ack_s[winner_s] = 1'b1;
      end else begin
         ack_s = '0;
      end
   end

   // Step sequencer: window timing, grant registration, budget and overrun tracking.
   always_ff @(posedge rt_clk or posedge rt_reset) begin
      if (rt_reset) begin
         state_q        <= ST_IDLE;
         ptr_q          <= PTR_LAST;
         win_cnt_q      <= '0;
         inject_count_q <= '0;
         packet_out_q   <= '0;
         write_req_q    <= 1'b0;
         step_done_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         write_req_q <= 1'b0;
         step_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (step_start) begin
                  state_q        <= ST_ACTIVE;
                  win_cnt_q      <= '0;
                  inject_count_q <= '0;
               end
            end
            ST_ACTIVE: begin
               if (grant_s) begin
                  packet_out_q   <= win_pkt_s;
                  write_req_q    <= 1'b1;
                  ptr_q          <= winner_s;
                  inject_count_q <= inject_count_q + CNT_W'(1);
               end
               if (step_start) begin
                  overrun_q <= 1'b1;
               end
               // Last window cycle still grants; step_done is raised for the DONE cycle.
               if (win_cnt_q == WIN_LAST) begin
                  state_q     <= ST_DONE;
                  step_done_q <= 1'b1;
               end else begin
                  win_cnt_q <= win_cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               // A step_start here is not queued; it only flags the overrun.
               if (step_start) begin
                  overrun_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack          = ack_s;
   assign packet_out   = packet_out_q;
   assign write_req    = write_req_q;
   assign step_done    = step_done_q;
   assign inject_count = inject_count_q;
   assign overrun      = overrun_q;

endmodule
